// File: rtl/sm_arb_pkg.sv
// ============================================================================
// Module   : sm_arb_pkg
// Purpose  : Shared definitions for the sync_manager request arbiter:
//            arbiter state encoding, default field widths / limits and the
//            log_length clamp helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sm_arb_pkg;

    localparam int LOG_LEN_WIDTH_DEF  = 5;
    localparam int MAX_LOG_LENGTH_DEF = 20;

    // ERR is only reachable when the ack timeout is built in.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_REQ  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } arb_state_t;

    // min(len, max_len); operands are widened to 32 bits by the caller.
    function automatic logic [31:0] clamp_len(input logic [31:0] len,
                                              input logic [31:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage : sm_arb_pkg

`default_nettype wire

// File: rtl/rr_priority_select.sv
// ============================================================================
// Module   : rr_priority_select
// Purpose  : Combinational round-robin picker. Returns the first set request
//            bit at or after ptr, wrapping modulo NUM_REQ.
// Ports    : req        in  NUM_REQ  request vector
//            ptr        in  IDX_W    round-robin start position
//            grant      out NUM_REQ  one-hot winner (0 when no request)
//            grant_idx  out IDX_W    winner index (0 when no request)
//            valid      out 1        at least one request bit set
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               valid
);

    logic [IDX_W-1:0] w_pos;

    // Scan from the farthest offset down to offset 0 so that the nearest
    // requester at or after ptr is the last one written and therefore wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        w_pos     = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_pos = IDX_W'((int'(ptr) + off) % NUM_REQ);
            if (req[w_pos]) begin
                valid     = 1'b1;
                grant_idx = w_pos;
            end
        end
        if (valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule : rr_priority_select

`default_nettype wire

// File: rtl/sm_request_arbiter.sv
// ============================================================================
// Module   : sm_request_arbiter
// Purpose  : Shares the single sync_manager buffer-request channel between
//            NUM_REQ readers. Round-robin arbitration, forwards the winner's
//            clamped log_length, holds SM_request until SM_ack and returns
//            the buffer address to the winner with a one-cycle REQ_done.
// Ports    : SYS_aclk        in  1            system clock
//            SYS_reset       in  1            synchronous active-high reset
//            REQ_request     in  NUM_REQ      per-requester request level
//            REQ_log_length  in  NUM_REQ*LLW  packed per-requester log2 length
//            REQ_done        out NUM_REQ      one-hot completion pulse
//            REQ_error       out NUM_REQ      one-hot timeout pulse
//            REQ_address     out MM_ADDR_WIDTH returned buffer address (held)
//            SM_request      out 1            request to sync_manager
//            SM_log_length   out LLW          forwarded length
//            SM_ack          in  1            sync_manager address strobe
//            SM_address      in  MM_ADDR_WIDTH buffer base address
//            ARB_busy        out 1            high whenever not IDLE
// Config   : define SM_ARB_TIMEOUT_EN to build the SM_ack timeout (ERR state,
//            TIMEOUT_CYCLES counter). Undefined: REQ waits forever and
//            REQ_error is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_request_arbiter
    import sm_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int MM_ADDR_WIDTH  = 32,
    parameter int LOG_LEN_WIDTH  = LOG_LEN_WIDTH_DEF,
    parameter int MAX_LOG_LENGTH = MAX_LOG_LENGTH_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               SYS_aclk,
    input  logic                               SYS_reset,
    input  logic [NUM_REQ-1:0]                 REQ_request,
    input  logic [NUM_REQ*LOG_LEN_WIDTH-1:0]   REQ_log_length,
    output logic [NUM_REQ-1:0]                 REQ_done,
    output logic [NUM_REQ-1:0]                 REQ_error,
    output logic [MM_ADDR_WIDTH-1:0]           REQ_address,
    output logic                               SM_request,
    output logic [LOG_LEN_WIDTH-1:0]           SM_log_length,
    input  logic                               SM_ack,
    input  logic [MM_ADDR_WIDTH-1:0]           SM_address,
    output logic                               ARB_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Reject illegal configurations at elaboration.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("sm_request_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    // ------------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------------
    arb_state_t                 r_state;
    logic [IDX_W-1:0]           r_rr_ptr;
    logic [IDX_W-1:0]           r_grant;
    logic [NUM_REQ-1:0]         r_grant_oh;
    logic                       r_sm_request;
    logic [LOG_LEN_WIDTH-1:0]   r_sm_log_length;
    logic [NUM_REQ-1:0]         r_req_done;
    logic [MM_ADDR_WIDTH-1:0]   r_req_address;
    logic                       r_busy;

    // ------------------------------------------------------------------------
    // Round-robin pick over the live request vector
    // ------------------------------------------------------------------------
    logic [NUM_REQ-1:0]         w_sel_oh;
    logic [IDX_W-1:0]           w_sel_idx;
    logic                       w_sel_valid;
    logic [LOG_LEN_WIDTH-1:0]   w_len_arr [NUM_REQ];
    logic [LOG_LEN_WIDTH-1:0]   w_sel_len;
    logic [LOG_LEN_WIDTH-1:0]   w_len_clamped;
    logic [IDX_W-1:0]           w_next_ptr;

    rr_priority_select #(
        .NUM_REQ   (NUM_REQ),
        .IDX_W     (IDX_W)
    ) u_rr_select (
        .req       (REQ_request),
        .ptr       (r_rr_ptr),
        .grant     (w_sel_oh),
        .grant_idx (w_sel_idx),
        .valid     (w_sel_valid)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_len_unpack
        assign w_len_arr[gi] = REQ_log_length[gi*LOG_LEN_WIDTH +: LOG_LEN_WIDTH];
    end

    assign w_sel_len     = w_len_arr[w_sel_idx];
    assign w_len_clamped = LOG_LEN_WIDTH'(clamp_len(32'(w_sel_len), 32'(MAX_LOG_LENGTH)));

    // Pointer moves just past the finished winner, wrapping to 0.
    assign w_next_ptr = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : (r_grant + IDX_W'(1));

`ifdef SM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0]   r_tmo_cnt;
    logic [NUM_REQ-1:0] r_req_error;
    logic               w_tmo_hit;

    assign w_tmo_hit = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign REQ_error = r_req_error;
`else
    assign REQ_error = '0;
`endif

    // ------------------------------------------------------------------------
    // Arbiter FSM: IDLE -> ARB -> REQ -> DONE (or ERR) -> IDLE
    // ------------------------------------------------------------------------
    always_ff @(posedge SYS_aclk) begin
        if (SYS_reset) begin
            r_state         <= ST_IDLE;
            r_rr_ptr        <= '0;
            r_grant         <= '0;
            r_grant_oh      <= '0;
            r_sm_request    <= 1'b0;
            r_sm_log_length <= '0;
            r_req_done      <= '0;
            r_req_address   <= '0;
            r_busy          <= 1'b0;
`ifdef SM_ARB_TIMEOUT_EN
            r_tmo_cnt       <= '0;
            r_req_error     <= '0;
`endif
        end else begin
            // Completion/error strobes are single-cycle.
            r_req_done <= '0;
`ifdef SM_ARB_TIMEOUT_EN
            r_req_error <= '0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (|REQ_request) begin
                        r_state <= ST_ARB;
                        r_busy  <= 1'b1;
                    end
                end

                ST_ARB: begin
                    // Requests may have dropped since IDLE; fall back quietly.
                    if (w_sel_valid) begin
                        r_grant         <= w_sel_idx;
                        r_grant_oh      <= w_sel_oh;
                        r_sm_log_length <= w_len_clamped;
                        r_sm_request    <= 1'b1;
                        r_state         <= ST_REQ;
`ifdef SM_ARB_TIMEOUT_EN
                        r_tmo_cnt       <= '0;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_REQ: begin
                    // The requester level is not consulted here: sync_manager
                    // cannot cancel, so a granted transfer always completes.
                    if (SM_ack) begin
                        r_sm_request  <= 1'b0;
                        r_req_address <= SM_address;
                        r_req_done    <= r_grant_oh;
                        r_state       <= ST_DONE;
                    end
`ifdef SM_ARB_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_sm_request <= 1'b0;
                        r_req_error  <= r_grant_oh;
                        r_state      <= ST_ERR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
                    end
`endif
                end

                ST_DONE, ST_ERR: begin
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_sm_request <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign REQ_done      = r_req_done;
    assign REQ_address   = r_req_address;
    assign SM_request    = r_sm_request;
    assign SM_log_length = r_sm_log_length;
    assign ARB_busy      = r_busy;

endmodule : sm_request_arbiter

`default_nettype wire

// File: tb/tb_sm_request_arbiter.sv
// ============================================================================
// Module   : tb_sm_request_arbiter
// Purpose  : Directed self-checking bench for sm_request_arbiter (NUM_REQ=4).
//            The timeout scenario is compiled in only with SM_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sm_request_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int LLW  = 5;

    logic              SYS_aclk;
    logic              SYS_reset;
    logic [NREQ-1:0]   REQ_request;
    logic [NREQ*LLW-1:0] REQ_log_length;
    logic [NREQ-1:0]   REQ_done;
    logic [NREQ-1:0]   REQ_error;
    logic [AW-1:0]     REQ_address;
    logic              SM_request;
    logic [LLW-1:0]    SM_log_length;
    logic              SM_ack;
    logic [AW-1:0]     SM_address;
    logic              ARB_busy;

    int n_checks = 0;
    int n_fail   = 0;

    sm_request_arbiter #(
        .NUM_REQ        (NREQ),
        .MM_ADDR_WIDTH  (AW),
        .LOG_LEN_WIDTH  (LLW),
        .MAX_LOG_LENGTH (20),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .SYS_aclk       (SYS_aclk),
        .SYS_reset      (SYS_reset),
        .REQ_request    (REQ_request),
        .REQ_log_length (REQ_log_length),
        .REQ_done       (REQ_done),
        .REQ_error      (REQ_error),
        .REQ_address    (REQ_address),
        .SM_request     (SM_request),
        .SM_log_length  (SM_log_length),
        .SM_ack         (SM_ack),
        .SM_address     (SM_address),
        .ARB_busy       (ARB_busy)
    );

    initial SYS_aclk = 1'b0;
    always #5 SYS_aclk = ~SYS_aclk;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge SYS_aclk);
        #1;
    endtask

    task automatic set_len(input int idx, input logic [LLW-1:0] v);
        REQ_log_length[idx*LLW +: LLW] = v;
    endtask

    // Advance until SM_request is high; n = edges taken, -1 if limit expired.
    task automatic wait_sm_req(input int limit, output int n);
        n = 0;
        while (SM_request !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        if (SM_request !== 1'b1) n = -1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        SYS_reset = 1'b1;
        tick(); tick();
        n_checks++; if (SM_request !== 1'b0) begin n_fail++; $display("FAIL reset_sm_request: got %0b want 0", SM_request); end
        n_checks++; if (REQ_done !== 4'b0) begin n_fail++; $display("FAIL reset_req_done: got %b want 0000", REQ_done); end
        n_checks++; if (REQ_error !== 4'b0) begin n_fail++; $display("FAIL reset_req_error: got %b want 0000", REQ_error); end
        n_checks++; if (REQ_address !== 32'd0) begin n_fail++; $display("FAIL reset_req_address: got %0h want 0", REQ_address); end
        n_checks++; if (SM_log_length !== 5'd0) begin n_fail++; $display("FAIL reset_sm_log_length: got %0d want 0", SM_log_length); end
        SYS_reset = 1'b0;
        tick();
        n_checks++; if (ARB_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", ARB_busy); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single();
        int n;
        set_len(1, 5'd3);
        REQ_request = 4'b0010;
        tick();
        n_checks++; if (ARB_busy !== 1'b1 || SM_request !== 1'b0) begin n_fail++; $display("FAIL single_arb_cycle: busy=%0b smreq=%0b want busy=1 smreq=0", ARB_busy, SM_request); end
        tick();
        n_checks++; if (SM_request !== 1'b1) begin n_fail++; $display("FAIL single_latency: SM_request=%0b want 1 two cycles after request", SM_request); end
        n_checks++; if (SM_log_length !== 5'd3) begin n_fail++; $display("FAIL single_log_length: got %0d want 3", SM_log_length); end
        // SM_request already seen high once; require four more high samples.
        n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (SM_request === 1'b1) n++;
        end
        SM_ack = 1'b1; SM_address = 32'd10;
        tick();
        SM_ack = 1'b0;
        n_checks++; if (n !== 5) begin n_fail++; $display("FAIL single_req_width: SM_request high %0d cycles want 5", n); end
        n_checks++; if (SM_request !== 1'b0) begin n_fail++; $display("FAIL single_req_drop: got %0b want 0", SM_request); end
        n_checks++; if (REQ_done !== 4'b0010) begin n_fail++; $display("FAIL single_done: got %b want 0010", REQ_done); end
        n_checks++; if (REQ_address !== 32'd10) begin n_fail++; $display("FAIL single_address: got %0d want 10", REQ_address); end
        n_checks++; if (REQ_error !== 4'b0) begin n_fail++; $display("FAIL single_error: got %b want 0000", REQ_error); end
        REQ_request = 4'b0000;
        tick();
        n_checks++; if (REQ_done !== 4'b0 || REQ_address !== 32'd10) begin n_fail++; $display("FAIL single_done_pulse: done=%b addr=%0d want 0000/10", REQ_done, REQ_address); end
        n_checks++; if (ARB_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%0b want 0", ARB_busy); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_contention();
        int n;
        int g;
        SYS_reset = 1'b1;
        tick();
        SYS_reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_len(i, LLW'(i + 4));
        REQ_request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = k % NREQ;
            wait_sm_req(12, n);
            n_checks++; if (n !== ((k == 0) ? 2 : 3)) begin n_fail++; $display("FAIL contention_gap[%0d]: %0d cycles want %0d", k, n, (k == 0) ? 2 : 3); end
            n_checks++; if (SM_log_length !== LLW'(g + 4)) begin n_fail++; $display("FAIL contention_len[%0d]: got %0d want %0d", k, SM_log_length, g + 4); end
            tick();
            SM_ack = 1'b1; SM_address = 32'(100 + k);
            tick();
            SM_ack = 1'b0;
            n_checks++; if (REQ_done !== (4'b0001 << g)) begin n_fail++; $display("FAIL contention_grant[%0d]: done=%b want %b", k, REQ_done, 4'b0001 << g); end
            n_checks++; if (REQ_address !== 32'(100 + k)) begin n_fail++; $display("FAIL contention_addr[%0d]: got %0d want %0d", k, REQ_address, 100 + k); end
        end
        REQ_request = 4'b0000;
        tick(); tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_clamp();
        int n;
        // rr_ptr is 1 here; requester 2 with an oversize length.
        set_len(2, 5'd31);
        REQ_request = 4'b0100;
        wait_sm_req(8, n);
        n_checks++; if (SM_log_length !== 5'd20) begin n_fail++; $display("FAIL clamp_31: got %0d want 20", SM_log_length); end
        // Ack in the very cycle SM_request first rises.
        SM_ack = 1'b1; SM_address = 32'd55;
        tick();
        SM_ack = 1'b0;
        n_checks++; if (REQ_done !== 4'b0100 || SM_request !== 1'b0) begin n_fail++; $display("FAIL clamp_same_cycle_ack: done=%b smreq=%0b want 0100/0", REQ_done, SM_request); end
        REQ_request = 4'b0000;
        tick();
        // Stray ack while idle must change nothing.
        SM_ack = 1'b1; SM_address = 32'd77;
        tick();
        SM_ack = 1'b0;
        tick();
        n_checks++; if (ARB_busy !== 1'b0 || REQ_done !== 4'b0 || REQ_address !== 32'd55) begin n_fail++; $display("FAIL stray_ack: busy=%0b done=%b addr=%0d want 0/0000/55", ARB_busy, REQ_done, REQ_address); end
        // Exactly at the limit passes through unchanged (rr_ptr now 3).
        set_len(3, 5'd20);
        REQ_request = 4'b1000;
        wait_sm_req(8, n);
        n_checks++; if (SM_log_length !== 5'd20) begin n_fail++; $display("FAIL clamp_20: got %0d want 20", SM_log_length); end
        SM_ack = 1'b1; SM_address = 32'd60;
        tick();
        SM_ack = 1'b0;
        n_checks++; if (REQ_done !== 4'b1000) begin n_fail++; $display("FAIL clamp_20_done: got %b want 1000", REQ_done); end
        REQ_request = 4'b0000;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_early_drop();
        int n;
        int hi;
        set_len(1, 5'd11);
        REQ_request = 4'b0010;
        wait_sm_req(8, n);
        tick();
        REQ_request = 4'b0000;
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (SM_request === 1'b1) hi++;
        end
        n_checks++; if (hi !== 3) begin n_fail++; $display("FAIL drop_hold: SM_request high %0d of 3 cycles", hi); end
        n_checks++; if (SM_log_length !== 5'd11) begin n_fail++; $display("FAIL drop_len: got %0d want 11", SM_log_length); end
        SM_ack = 1'b1; SM_address = 32'h1234;
        tick();
        SM_ack = 1'b0;
        n_checks++; if (REQ_done !== 4'b0010 || REQ_address !== 32'h1234) begin n_fail++; $display("FAIL drop_done: done=%b addr=%0h want 0010/1234", REQ_done, REQ_address); end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        int n;
        int seen;
        // rr_ptr is 2 here; requester 3 is granted.
        REQ_request = 4'b1000;
        wait_sm_req(8, n);
        tick();
        SYS_reset = 1'b1; REQ_request = 4'b0000;
        tick();
        SYS_reset = 1'b0;
        n_checks++; if (SM_request !== 1'b0 || ARB_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid: smreq=%0b busy=%0b want 0/0", SM_request, ARB_busy); end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (REQ_done !== 4'b0 || REQ_error !== 4'b0) seen++;
            tick();
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_pulse: %0d cycles with done/error want 0", seen); end
        // After reset rr_ptr is 0, so requester 0 beats requester 3.
        set_len(0, 5'd6); set_len(3, 5'd7);
        REQ_request = 4'b1001;
        wait_sm_req(8, n);
        n_checks++; if (n !== 2 || SM_log_length !== 5'd6) begin n_fail++; $display("FAIL rst_mid_new: lat=%0d len=%0d want 2/6", n, SM_log_length); end
        SM_ack = 1'b1; SM_address = 32'd200;
        tick();
        SM_ack = 1'b0;
        n_checks++; if (REQ_done !== 4'b0001 || REQ_address !== 32'd200) begin n_fail++; $display("FAIL rst_mid_done: done=%b addr=%0d want 0001/200", REQ_done, REQ_address); end
        REQ_request = 4'b0000;
        tick(); tick();
    endtask

`ifdef SM_ARB_TIMEOUT_EN
    // ------------------------------------------------------------------
    task automatic test_timeout();
        int n;
        int hi;
        // rr_ptr is 1; requesters 1 and 2 pending, 1 wins and times out.
        set_len(1, 5'd8); set_len(2, 5'd9);
        REQ_request = 4'b0110;
        wait_sm_req(8, n);
        hi = 1;
        while (hi < 40) begin
            tick();
            if (SM_request !== 1'b1) break;
            hi++;
        end
        n_checks++; if (hi !== 16) begin n_fail++; $display("FAIL timeout_len: SM_request high %0d cycles want 16", hi); end
        n_checks++; if (REQ_error !== 4'b0010 || REQ_done !== 4'b0) begin n_fail++; $display("FAIL timeout_error: err=%b done=%b want 0010/0000", REQ_error, REQ_done); end
        REQ_request = 4'b0100;
        wait_sm_req(8, n);
        n_checks++; if (n !== 3 || SM_log_length !== 5'd9) begin n_fail++; $display("FAIL timeout_next: gap=%0d len=%0d want 3/9", n, SM_log_length); end
        SM_ack = 1'b1; SM_address = 32'd300;
        tick();
        SM_ack = 1'b0;
        n_checks++; if (REQ_done !== 4'b0100 || REQ_error !== 4'b0) begin n_fail++; $display("FAIL timeout_next_done: done=%b err=%b want 0100/0000", REQ_done, REQ_error); end
        REQ_request = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        SYS_reset      = 1'b1;
        REQ_request    = '0;
        REQ_log_length = '0;
        SM_ack         = 1'b0;
        SM_address     = '0;
        test_reset();
        test_single();
        test_contention();
        test_clamp();
        test_early_drop();
        test_reset_mid();
`ifdef SM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_sm_request_arbiter

`default_nettype wire
